// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - fetch_state_t : fetch FSM states (IDLE / BUSY / DISCARD)
//   - DEF_*         : default configuration constants
//   - fetch_entry_t : prefetch FIFO entry layout {word, pc} at default widths
//   - ptr_width()   : FIFO pointer width, never zero even for DEPTH=1
package fetch_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // The FIFO stores entries packed in this order ({word, pc}) for any widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] word;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write an entry (ignored when full unless popping too)
//   pop              : drop the head entry (ignored when empty)
//   flush            : empty the FIFO; overrides push and pop
//   head             : head entry, all zeros when empty
//   full, empty      : occupancy flags
//   count            : current occupancy, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + DEF_ADDR_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not fill the pointer range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding reads
// to instruction memory, buffers returned words in a prefetch FIFO and
// presents the head word to the controller as ir / ir_pc / ir_valid.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   imem_req, imem_addr   : read request, held with a stable address until ack
//   imem_ack, imem_rdata  : one-cycle acknowledge with the read word
//   ir, ir_pc, ir_valid   : head instruction, its address, valid flag
//   ir_take               : controller consumes the head word
//   pc_load, pc_load_val  : redirect; flushes prefetched words
//   fetch_stall_cnt       : cycles with no valid instruction, saturating
// Optional build macro FETCH_PERF_CNT_EN enables fetch_stall_cnt; without it
// the output is tied to zero.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_take,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [15:0]       fetch_stall_cnt
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + ADDR_W;

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] fpc_reg, fpc_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W:0]     occ_after;
    logic               space_after;

    // A redirect wins over a same-cycle take.
    assign fifo_pop = ir_take && !fifo_empty && !pc_load;

    // Occupancy after an ack cycle's push and any simultaneous pop; decides
    // whether the next request can go out back-to-back.
    assign occ_after   = {1'b0, fifo_count} + (CNT_W+1)'(1) - (CNT_W+1)'(fifo_pop);
    assign space_after = (occ_after < (CNT_W+1)'(DEPTH));

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (fifo_push),
        .push_data ({imem_rdata, fpc_reg}),
        .pop       (fifo_pop),
        .flush     (pc_load),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {ir, ir_pc} = fifo_head;
    assign ir_valid    = !fifo_empty;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            fpc_reg   <= ADDR_W'(RESET_PC);
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fpc_reg   <= fpc_next;
            addr_reg  <= addr_next;
        end
    end

    // Next-state logic. addr_reg holds the address of the outstanding request,
    // separate from fpc so a redirect cannot disturb a request still on the bus.
    always_comb begin
        state_next = state_reg;
        fpc_next   = fpc_reg;
        addr_next  = addr_reg;
        if (pc_load) begin
            fpc_next = pc_load_val;
            case (state_reg)
                // An un-acked request must still complete; its data is dropped.
                BUSY, DISCARD: state_next = imem_ack ? IDLE : DISCARD;
                default:       state_next = IDLE;
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_full) begin
                        state_next = BUSY;
                        addr_next  = fpc_reg;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        fpc_next = fpc_reg + 1'b1;
                        if (space_after) begin
                            addr_next = fpc_reg + 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    // FIFO was flushed by the redirect, so there is room.
                    if (imem_ack) begin
                        state_next = BUSY;
                        addr_next  = fpc_reg;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        imem_req  = (state_reg != IDLE);
        imem_addr = addr_reg;
        fifo_push = (state_reg == BUSY) && imem_ack && !pc_load;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
        end else if (!ir_valid && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign fetch_stall_cnt = stall_cnt_reg;
`else
    assign fetch_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_take = 1'b0;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_load_val = '0;
    logic [15:0] fetch_stall_cnt;

    int tests = 0;
    int fails = 0;

    // Memory responder controls
    bit mem_en = 1'b0;
    int mem_lat = 1;
    int lat_cnt = 0;
    bit ack_by_resp = 1'b0;

    // Scoreboard: {word, pc} expected in consumption order
    logic [23:0] sb_q[$];

    instr_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .DEPTH    (2),
        .RESET_PC (0)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_take         (ir_take),
        .pc_load         (pc_load),
        .pc_load_val     (pc_load_val),
        .fetch_stall_cnt (fetch_stall_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [7:0] a);
        sb_q.push_back({mem_word(a), a});
    endtask

    task automatic pulse_load(input logic [7:0] v);
        pc_load = 1'b1;
        pc_load_val = v;
        tick(1);
        pc_load = 1'b0;
    endtask

    task automatic wait_idle_full(input int budget);
        for (int n = 0; n < budget && !(!imem_req && ir_valid); n++) tick(1);
        check("idle_full_reached", {imem_req, ir_valid}, 2'b01);
    endtask

    task automatic wait_req(input int budget);
        for (int n = 0; n < budget && !imem_req; n++) tick(1);
        check("req_reached", imem_req, 1'b1);
    endtask

    task automatic drain(input int budget);
        ir_take = 1'b1;
        for (int n = 0; n < budget && sb_q.size() != 0; n++) tick(1);
        ir_take = 1'b0;
        check("sb_drained", sb_q.size(), 0);
    endtask

    // Memory responder: acks the outstanding request mem_lat cycles after it
    // is first seen, returning mem_word(addr). Leaves manual acks alone.
    initial forever begin
        @(posedge clk);
        #2;
        if (ack_by_resp) begin
            imem_ack = 1'b0;
            ack_by_resp = 1'b0;
            lat_cnt = 0;
        end else if (mem_en && imem_req) begin
            if (lat_cnt == mem_lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
                ack_by_resp = 1'b1;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Consumption monitor: every accepted take is compared against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (reset_n && ir_valid && ir_take && !pc_load) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                $display("[TB] take ir_pc=%02h ir=%04h exp_pc=%02h exp_ir=%04h",
                         ir_pc, ir, e[7:0], e[23:8]);
                check("sb_pc", ir_pc, e[7:0]);
                check("sb_word", ir, e[23:8]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a;
        logic [15:0] exp_stall;

        // Reset state
        #2;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_ir", ir, 16'h0000);
        check("rst_ir_pc", ir_pc, 8'h00);
        check("rst_valid", ir_valid, 1'b0);
        check("rst_stall", fetch_stall_cnt, 16'h0000);

        // Release, 1-cycle memory, no take: fill FIFO with 0 and 1
        mem_en = 1'b1;
        mem_lat = 1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 8'h00);
        tick(6);
        check("full_req_drop", imem_req, 1'b0);
        check("full_valid", ir_valid, 1'b1);
        check("full_ir_pc", ir_pc, 8'h00);
        check("full_ir", ir, mem_word(8'h00));

        // Continuous take with 3-cycle latency: in-order stream
        mem_lat = 3;
        for (int i = 0; i < 10; i++) expect_pc(8'(i));
        drain(200);
        wait_idle_full(40);

        // PC wrap FE, FF, 00, 01
        mem_lat = 0;
        pulse_load(8'hFE);
        a = 8'hFE;
        repeat (4) begin
            expect_pc(a);
            a = a + 8'd1;
        end
        drain(100);
        wait_idle_full(40);

        // Redirect while request to 05 is outstanding
        mem_en = 1'b0;
        pulse_load(8'h05);
        wait_req(5);
        check("t4_addr05", imem_addr, 8'h05);
        pulse_load(8'h40);
        check("t4_flush_valid", ir_valid, 1'b0);
        check("t4_req_held", imem_req, 1'b1);
        check("t4_addr_held", imem_addr, 8'h05);
        tick(2);
        check("t4_addr_held2", imem_addr, 8'h05);
        expect_pc(8'h40);
        expect_pc(8'h41);
        mem_lat = 1;
        mem_en = 1'b1;
        for (int n = 0; n < 10 && !(imem_req && imem_addr == 8'h40); n++) tick(1);
        check("t4_next_req", {imem_req, imem_addr}, {1'b1, 8'h40});
        drain(60);
        wait_idle_full(40);

        // Redirect, ack and take all in the same cycle
        mem_en = 1'b0;
        pulse_load(8'h20);
        wait_req(5);
        check("t5_addr20", imem_addr, 8'h20);
        imem_ack = 1'b1;
        imem_rdata = mem_word(8'h20);
        tick(1);
        imem_ack = 1'b0;
        check("t5_valid", ir_valid, 1'b1);
        check("t5_ir_pc", ir_pc, 8'h20);
        check("t5_next_addr", {imem_req, imem_addr}, {1'b1, 8'h21});
        imem_ack = 1'b1;
        imem_rdata = mem_word(8'h21);
        pc_load = 1'b1;
        pc_load_val = 8'h60;
        ir_take = 1'b1;
        tick(1);
        imem_ack = 1'b0;
        pc_load = 1'b0;
        ir_take = 1'b0;
        check("t5_flush_valid", ir_valid, 1'b0);
        check("t5_flush_ir", ir, 16'h0000);
        check("t5_flush_req", imem_req, 1'b0);
        tick(1);
        check("t5_load_req", {imem_req, imem_addr}, {1'b1, 8'h60});
        expect_pc(8'h60);
        expect_pc(8'h61);
        mem_lat = 1;
        mem_en = 1'b1;
        drain(60);
        wait_idle_full(40);

        // Reset mid-request, then stall counter with memory stalled
        mem_en = 1'b0;
        pulse_load(8'h80);
        wait_req(5);
        reset_n = 1'b0;
        #1;
        check("arst_req", imem_req, 1'b0);
        check("arst_addr", imem_addr, 8'h00);
        check("arst_valid", ir_valid, 1'b0);
        check("arst_stall", fetch_stall_cnt, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(12);
`ifdef FETCH_PERF_CNT_EN
        exp_stall = 16'd12;
`else
        exp_stall = 16'd0;
`endif
        check("stall_cnt", fetch_stall_cnt, exp_stall);
        check("rst2_req", {imem_req, imem_addr}, {1'b1, 8'h00});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the microprogrammed controller; owns the program counter and supplies IR.
- Issues single-outstanding read requests to the instruction memory and buffers returned words in a small prefetch FIFO.
- Presents the head word as `ir`/`ir_valid`; the controller consumes it with `ir_take`.
- Redirects on a controller PC-load (jump/branch) and discards stale prefetched words.

Parameters:
- ADDR_W, 8, instruction address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 16, instruction word width; matches controller IR width.
- DEPTH, 2, prefetch FIFO entries; power of two, at least 1.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request; held high until acknowledged.
- imem_addr  out  ADDR_W  read address; stable while `imem_req`=1.
- imem_ack  in  1  one-cycle pulse; `imem_rdata` valid in the same cycle.
- imem_rdata  in  DATA_W  returned instruction word.
- ir  out  DATA_W  head FIFO word; 0 when empty.
- ir_pc  out  ADDR_W  address of the word on `ir`.
- ir_valid  out  1  `ir` holds a valid instruction.
- ir_take  in  1  controller consumes the head word; ignored when `ir_valid`=0.
- pc_load  in  1  redirect request (from a controller OPs bit).
- pc_load_val  in  ADDR_W  redirect target.
- fetch_stall_cnt  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset (async assert): fpc=RESET_PC, FIFO empty, state=IDLE. Outputs: `imem_req`=0, `imem_addr`=0, `ir`=0, `ir_pc`=0, `ir_valid`=0, `fetch_stall_cnt`=0.
- States:
  - IDLE: no request outstanding. Issue when FIFO occupancy < DEPTH, then go to BUSY with `imem_req`=1 and `imem_addr`=fpc.
  - BUSY: on `imem_ack`, push {rdata, fpc} and set fpc=fpc+1 (wraps 2^ADDR_W-1 -> 0). Then:
    - more space available (accounting for a same-cycle pop): re-issue next cycle, stay BUSY;
    - otherwise: go to IDLE.
  - DISCARD: waiting on the ack of a request made stale by a redirect. On ack, drop rdata, then issue at fpc next cycle.
- Bus rule: `imem_req` never drops and `imem_addr` never changes before ack. At most one request outstanding.
- Latency:
  - first `imem_req` is asserted on the first clk edge after `reset_n` deasserts;
  - an ack in cycle N gives `ir_valid`=1 in cycle N+1 (registered FIFO);
  - steady-state throughput is one word per ack, no bubble while the FIFO has space.
- `pc_load` (highest priority):
  - next cycle: FIFO flushed, `ir_valid`=0, fpc=`pc_load_val`;
  - if BUSY with no ack this cycle: go to DISCARD;
  - if ack arrives in the same cycle: its data is dropped and the FSM goes to IDLE/issue;
  - `ir_take` in the same cycle is ignored;
  - back-to-back `pc_load`: the last value wins.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- `ir_take` with `ir_valid`=0: no effect.
- FIFO wrap: pointers are ADDR-independent, modulo DEPTH. No overflow is possible, since issue is gated by occupancy plus outstanding.
- `reset_n` asserted mid-request: all state clears immediately. A late `imem_ack` after reset is ignored while IDLE.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: `fetch_stall_cnt` increments every cycle with `ir_valid`=0 and `reset_n`=1.
  - It saturates at 16'hFFFF.
  - It clears on reset only.
- Undefined: `fetch_stall_cnt` is tied to 16'h0000 and no counter flops are inferred.

Decomposition:
- Package `fetch_pkg` holds:
  - the FSM state enum {IDLE, BUSY, DISCARD};
  - default constants for ADDR_W, DATA_W, DEPTH, RESET_PC;
  - the FIFO entry struct {word, pc}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with push, pop, flush, full, empty and a count output; asynchronous active-low reset.
- The FSM, PC and counter live in the top module.

Test Plan:
- Reset release, memory acks 1 cycle after each req, no take: addresses 0 and 1 are fetched, `ir_valid`=1 with `ir_pc`=0, then `imem_req` drops (FIFO full, DEPTH=2).
- Continuous `ir_take` with 3-cycle ack latency: `ir`/`ir_pc` sequence 0,1,2,... in order, with no duplicates or skips.
- fpc at 8'hFF: next fetch address is 8'h00 and `ir_pc` shows FF then 00.
- `pc_load`=1 with val=8'h40 while a request to 8'h05 is outstanding:
  - the 8'h05 data is discarded;
  - the next req is to 8'h40;
  - the first valid `ir_pc`=8'h40.
- `pc_load` and `imem_ack` in the same cycle, plus `ir_take`: FIFO empty next cycle, take ignored, next req to the load value.
- With FETCH_PERF_CNT_EN defined, stall memory acks for 10 cycles after reset: `fetch_stall_cnt` ≥ 10. Without the macro: the counter reads 0.
